dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port: services single-word load/store requests over a req/ack handshake with a configurable number of wait states.
- Holds a word-addressed data array. Flags misaligned and out-of-range accesses.
- Lets the core's stall logic be exercised against a multi-cycle memory instead of a zero-latency array.

---
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bus between the core data port and the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-addressed data memory with a fixed number of wait states,
//               req/ack handshake and misalignment / range fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int LATENCY    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int         c_depth    = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_lat_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [c_depth];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_fault;
  logic [DEPTH_LOG2-1:0] w_idx;

  // Fault and index come from the captured address, so bus changes after
  // acceptance cannot affect the access.
  assign w_idx   = r_addr[DEPTH_LOG2+1:2];
  assign w_fault = (|r_addr[1:0]) || (|r_addr[31:DEPTH_LOG2+2]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.we_i;
        r_addr  <= bus.addr_i;
        r_wdata <= bus.wdata_i;
        r_cnt   <= c_lat_init;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_commit) begin
        r_err   <= w_fault;
        r_rdata <= (!r_we && !w_fault) ? r_mem[w_idx] : 32'd0;
      end else if (r_state == ST_RESP) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Array has no reset; an abort forces IDLE asynchronously, so no commit
  // can occur on an edge while reset is held.
  always_ff @(posedge clk_i) begin
    if (w_commit && r_we && !w_fault) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign bus.ack_o   = (r_state == ST_RESP);
  assign bus.busy_o  = (r_state != ST_IDLE);
  assign bus.rdata_o = r_rdata;
  assign bus.err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder: vector table, random
//               traffic against a memory model, hold-request and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] m_mem [DEPTH];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_LOG2 (5),
    .LATENCY    (LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a plain array of words; a fault is any non-word-aligned or
  // beyond-array byte address.
  function automatic void model_step(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata,
                                     output logic [31:0] rd, output logic err);
    err = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
    rd  = 32'd0;
    if (!err) begin
      if (we) m_mem[int'(addr >> 2)] = wdata;
      else    rd = m_mem[int'(addr >> 2)];
    end
  endfunction

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    @(posedge clk);
    #1;
    bus.req_i   = 1'b0;
    bus.we_i    = ~we;
    bus.addr_i  = $urandom;
    bus.wdata_i = $urandom;
    for (int j = 0; j <= LAT + 1; j++) begin
      @(negedge clk);
      if (j < LAT) begin
        check("wait_ack", {31'd0, bus.ack_o}, 32'd0);
        check("wait_busy", {31'd0, bus.busy_o}, 32'd1);
      end else if (j == LAT) begin
        check("resp_ack", {31'd0, bus.ack_o}, 32'd1);
        check("resp_busy", {31'd0, bus.busy_o}, 32'd1);
        check("resp_rdata", bus.rdata_o, exp_rd);
        check("resp_err", {31'd0, bus.err_o}, {31'd0, exp_err});
      end else begin
        check("post_ack", {31'd0, bus.ack_o}, 32'd0);
        check("post_busy", {31'd0, bus.busy_o}, 32'd0);
        check("post_rdata", bus.rdata_o, 32'd0);
        check("post_err", {31'd0, bus.err_o}, 32'd0);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ack"}, {31'd0, bus.ack_o}, 32'd0);
    check({name, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
    check({name, "_rdata"}, bus.rdata_o, 32'd0);
    check({name, "_err"}, {31'd0, bus.err_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eerr;
    logic [31:0] a;
    logic        w;
    logic        exp_ack;
    int          acc;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0,          1'b1};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0080, 32'h0,         32'h0,          1'b1};
    vecs[5] = '{1'b1, 32'h0000_007C, 32'h0BAD_F00D, 32'h0,          1'b0};
    vecs[6] = '{1'b0, 32'h0000_007C, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,          1'b1};
    vecs[8] = '{1'b1, 32'h0000_0003, 32'h5555_AAAA, 32'h0,          1'b1};
    vecs[9] = '{1'b0, 32'h0000_0012, 32'h0,         32'h0,          1'b1};

    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'd0;
    bus.wdata_i = 32'd0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);
      model_step(vecs[i].we, vecs[i].addr, vecs[i].wdata, erd, eerr);
    end

    // Fill every word so that later model loads are fully determined.
    for (int i = 0; i < DEPTH; i++) begin
      a = 32'(i * 4);
      w = 1'b1;
      erd = $urandom;
      model_step(w, a, erd, erd, eerr);
      txn(1'b1, a, m_mem[i], 32'd0, 1'b0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [31:0] wd;
      case ($urandom_range(0, 5))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      model_step(w, a, wd, erd, eerr);
      txn(w, a, wd, erd, eerr);
    end

    // Held request with the address toggling every cycle: acceptance happens
    // on the first edge seen in IDLE, i.e. every LAT+2 edges.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_ack = (c >= LAT + 1) && (((c - (LAT + 1)) % (LAT + 2)) == 0);
      check("hold_ack", {31'd0, bus.ack_o}, {31'd0, exp_ack});
      if (exp_ack) begin
        acc = c - (LAT + 1);
        check("hold_rdata", bus.rdata_o, m_mem[(acc % 2 == 1) ? 1 : 0]);
        check("hold_err", {31'd0, bus.err_o}, 32'd0);
      end
      bus.req_i   = 1'b1;
      bus.we_i    = 1'b0;
      bus.addr_i  = (c % 2 == 1) ? 32'h4 : 32'h0;
    end
    @(negedge clk);
    bus.req_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("hold_end");

    // Reset one cycle after acceptance aborts the store with no ack.
    model_step(1'b1, 32'h8, 32'hDEAD_BEEF, erd, eerr);
    txn(1'b1, 32'h8, 32'hDEAD_BEEF, 32'd0, 1'b0);
    @(negedge clk);
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = 32'h8;
    bus.wdata_i = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    check("abort_busy_pre", {31'd0, bus.busy_o}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("abort_async");
    @(negedge clk);
    check_idle_outputs("abort_held");
    rst = 1'b0;
    for (int j = 0; j < LAT + 3; j++) begin
      @(negedge clk);
      check("abort_no_ack", {31'd0, bus.ack_o}, 32'd0);
    end
    txn(1'b0, 32'h8, 32'd0, 32'hDEAD_BEEF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
